// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU (a_*) and
// load-return (m_*) writeback sources, each behind a one-entry buffer.
// Ports: clk, rst (async, active-high); a_valid/a_ready/a_addr/a_data and
// m_valid/m_ready/m_addr/m_data source handshakes; rf_we/rf_dst_addr/rf_dst
// registered write port; pend_mask per-register pending-write mask.
// Optional macro RF_WB_PENDING_EN enables pend_mask; otherwise it is zero.
module rf_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [ADDR_W-1:0]        m_addr,
  input  logic [DATA_W-1:0]        m_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_dst_addr,
  output logic [DATA_W-1:0]        rf_dst,
  output logic [(1<<ADDR_W)-1:0]   pend_mask
);

  logic              buf_a_v, buf_m_v;
  logic              buf_a_age, buf_m_age;
  logic [ADDR_W-1:0] buf_a_addr, buf_m_addr;
  logic [DATA_W-1:0] buf_a_data, buf_m_data;
  logic              rr_m;
  logic              grant_a, grant_m;
  logic              acc_a, acc_m;
  logic              keep_a, keep_m;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (buf_a_v && buf_m_v) begin
      if (buf_a_addr == buf_m_addr && buf_a_addr != '0) begin
        // A wins only when strictly older; a tie means both
        // arrived together and the load is the older instruction.
        if (!buf_a_age && buf_m_age) grant_a = 1'b1;
        else                         grant_m = 1'b1;
      end else if (rr_m) begin
        grant_m = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = buf_a_v;
      grant_m = buf_m_v;
    end
  end

  assign a_ready = !rst && (!buf_a_v || grant_a);
  assign m_ready = !rst && (!buf_m_v || grant_m);
  assign acc_a   = a_valid && a_ready;
  assign acc_m   = m_valid && m_ready;
  // The other buffer stays occupied across this edge.
  assign keep_a  = buf_a_v && !grant_a;
  assign keep_m  = buf_m_v && !grant_m;

  assign sel_addr = grant_m ? buf_m_addr : buf_a_addr;
  assign sel_data = grant_m ? buf_m_data : buf_a_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_a_v    <= 1'b0;
      buf_a_age  <= 1'b0;
      buf_a_addr <= '0;
      buf_a_data <= '0;
    end else if (acc_a) begin
      buf_a_v    <= 1'b1;
      buf_a_age  <= keep_m;
      buf_a_addr <= a_addr;
      buf_a_data <= a_data;
    end else if (grant_a) begin
      buf_a_v    <= 1'b0;
      buf_a_age  <= 1'b0;
    end else if (acc_m && keep_a) begin
      buf_a_age  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_m_v    <= 1'b0;
      buf_m_age  <= 1'b0;
      buf_m_addr <= '0;
      buf_m_data <= '0;
    end else if (acc_m) begin
      buf_m_v    <= 1'b1;
      buf_m_age  <= keep_a;
      buf_m_addr <= m_addr;
      buf_m_data <= m_data;
    end else if (grant_m) begin
      buf_m_v    <= 1'b0;
      buf_m_age  <= 1'b0;
    end else if (acc_a && keep_m) begin
      buf_m_age  <= 1'b0;
    end
  end

  // rr_m set means M is favoured on the next different-address conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_m <= 1'b0;
    end else if (buf_a_v && buf_m_v) begin
      rr_m <= grant_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we       <= 1'b0;
      rf_dst_addr <= '0;
      rf_dst      <= '0;
    end else if (grant_a || grant_m) begin
      rf_we       <= (sel_addr != '0);
      rf_dst_addr <= sel_addr;
      rf_dst      <= sel_data;
    end else begin
      rf_we       <= 1'b0;
    end
  end

`ifdef RF_WB_PENDING_EN
  always_comb begin
    pend_mask = '0;
    if (buf_a_v) pend_mask[buf_a_addr] = 1'b1;
    if (buf_m_v) pend_mask[buf_m_addr] = 1'b1;
    if (rf_we)   pend_mask[rf_dst_addr] = 1'b1;
    pend_mask[0] = 1'b0;
  end
`else
  assign pend_mask = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and random writeback traffic against a
// timestamp-based behavioural model of the write-port arbiter.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, m_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_addr, m_addr;
  logic [31:0] a_data, m_data;
  logic        rf_we;
  logic [4:0]  rf_dst_addr;
  logic [31:0] rf_dst;
  logic [31:0] pend_mask;

  rf_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_data(m_data),
    .rf_we(rf_we), .rf_dst_addr(rf_dst_addr),
    .rf_dst(rf_dst), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Model: each slot remembers the cycle it was accepted in.
  bit          ma_v, mm_v;
  logic [4:0]  ma_a, mm_a;
  logic [31:0] ma_d, mm_d;
  int          ma_t, mm_t;
  bit          last_win_m;
  int          cyc;
  bit          e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_dst;

  task automatic model_reset();
    ma_v = 0; mm_v = 0;
    ma_t = 0; mm_t = 0;
    last_win_m = 1;
    e_we = 0; e_addr = '0; e_dst = '0;
  endtask

  function automatic logic [31:0] exp_pend();
    logic [31:0] p;
    p = '0;
`ifdef RF_WB_PENDING_EN
    if (ma_v) p[ma_a] = 1'b1;
    if (mm_v) p[mm_a] = 1'b1;
    if (e_we) p[e_addr] = 1'b1;
    p[0] = 1'b0;
`endif
    return p;
  endfunction

  task automatic step(input bit av, input logic [4:0] aa,
                      input logic [31:0] ad, input bit mv,
                      input logic [4:0] ma, input logic [31:0] md,
                      output bit acc_a, output bit acc_m);
    bit ga, gm, both;
    a_valid = av; a_addr = aa; a_data = ad;
    m_valid = mv; m_addr = ma; m_data = md;
    #1;
    ga = 0; gm = 0;
    both = ma_v && mm_v;
    if (both) begin
      if (ma_a == mm_a && ma_a != 0) begin
        if (mm_t <= ma_t) gm = 1; else ga = 1;
      end else if (last_win_m) ga = 1;
      else gm = 1;
    end else begin
      ga = ma_v; gm = mm_v;
    end
    chk("a_ready", a_ready, !ma_v || ga);
    chk("m_ready", m_ready, !mm_v || gm);
    chk("rf_we", rf_we, e_we);
    chk("rf_dst_addr", rf_dst_addr, e_addr);
    chk("rf_dst", rf_dst, e_dst);
    chk("pend_mask", pend_mask, exp_pend());
    acc_a = av && (!ma_v || ga);
    acc_m = mv && (!mm_v || gm);
    if (ga || gm) begin
      e_addr = gm ? mm_a : ma_a;
      e_dst  = gm ? mm_d : ma_d;
      e_we   = (e_addr != 0);
    end else e_we = 0;
    if (both) last_win_m = gm;
    if (ga) ma_v = 0;
    if (gm) mm_v = 0;
    if (acc_a) begin ma_v = 1; ma_a = aa; ma_d = ad; ma_t = cyc; end
    if (acc_m) begin mm_v = 1; mm_a = ma; mm_d = md; mm_t = cyc; end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    bit x, y;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, x, y);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_addr", rf_dst_addr, 0);
    chk("rst_dst", rf_dst, 0);
    chk("rst_pend", pend_mask, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_m_ready", m_ready, 1);
  endtask

  initial begin
    bit xa, xm;
    int ia, im;
    bit pa, pm;
    bit av, mv;
    logic [4:0] aa, ma;
    logic [31:0] ad, md;
    rst = 1'b1;
    a_valid = 0; a_addr = 0; a_data = 0;
    m_valid = 0; m_addr = 0; m_data = 0;
    cyc = 0;
    model_reset();
    #12;
    do_reset();
    @(posedge clk); #1;

    // Single write to r5.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, xa, xm);
    chk("sw_acc", xa, 1);
`ifdef RF_WB_PENDING_EN
    chk("sw_pend1", pend_mask, 32'h20);
`else
    chk("sw_pend1", pend_mask, 0);
`endif
    idle(1);
    chk("sw_we", rf_we, 1);
    chk("sw_addr", rf_dst_addr, 5);
    chk("sw_dst", rf_dst, 32'hDEADBEEF);
    idle(1);
    chk("sw_we_off", rf_we, 0);
    chk("sw_pend_off", pend_mask, 0);

    // Same-cycle conflict on r3: M first, then A.
    step(1, 3, 32'h11, 1, 3, 32'h22, xa, xm);
    chk("cf_a_ready", a_ready, 0);
    idle(1);
    chk("cf_first", rf_dst, 32'h22);
    idle(1);
    chk("cf_second", rf_dst, 32'h11);
    chk("cf_addr", rf_dst_addr, 3);
    idle(1);

    // Register 0 write from M.
    step(0, 0, 0, 1, 0, 32'hFFFFFFFF, xa, xm);
    chk("r0_acc", xm, 1);
    chk("r0_pend", pend_mask, 0);
    idle(1);
    chk("r0_we", rf_we, 0);
    idle(1);

    // Dual streams of 8 writes each to distinct registers.
    ia = 0; im = 0;
    while (ia < 8 || im < 8) begin
      step(ia < 8, 5'(1 + ia), 32'hA000 + ia,
           im < 8, 5'(16 + im), 32'hB000 + im, xa, xm);
      if (xa) ia++;
      if (xm) im++;
    end
    idle(3);

    // Both buffers full, then reset mid-operation.
    step(1, 7, 32'h77, 1, 9, 32'h99, xa, xm);
    do_reset();
    idle(2);

    // Random traffic; unaccepted requests are held stable.
    pa = 0; pm = 0;
    av = 0; mv = 0; aa = 0; ma = 0; ad = 0; md = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pa) begin
        av = ($urandom_range(0, 3) != 0);
        aa = 5'($urandom_range(0, 3));
        ad = $urandom;
      end
      if (!pm) begin
        mv = ($urandom_range(0, 3) != 0);
        ma = 5'($urandom_range(0, 3));
        md = $urandom;
      end
      step(av, aa, ad, mv, ma, md, xa, xm);
      pa = av && !xa;
      pm = mv && !xm;
      if (i == 200) begin
        do_reset();
        pa = 0; pm = 0;
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
